rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter that shares one resource between eight requesters. It returns a registered one-hot grant plus the 3-bit binary index of the winner, with the index produced by an 8-to-3 encoder stage. It sits in front of the shared datapath, and its grant index drives that datapath's select lines. A hold-limit counter keeps any single requester from monopolising the resource.

## Interface
- MAX_HOLD, default 16: maximum number of consecutive cycles one grant may persist. 0 means unlimited. Legal range is 0..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  arbiter enable. Low means no new grant is issued and any current grant is revoked.
- req  in  8  request vector; bit i is requester i and is level-sensitive.
- gnt  out  8  registered one-hot grant, or all zeros.
- gnt_idx  out  3  binary index of the set bit of gnt; 3'b000 when gnt_vld=0.
- gnt_vld  out  1  high exactly when gnt is non-zero.
- timeout  out  1  one-cycle pulse on the cycle after a grant is revoked by MAX_HOLD.

## Operation
- State machine with two states, IDLE and GRANT. Internal state is a 3-bit priority pointer ptr and an 8-bit hold counter hold_cnt.
- IDLE:
  - If en=1 and req≠0, the winner is the first set bit of req, searching ptr, ptr+1, …, ptr+7 modulo 8.
  - The winner is latched into gnt and gnt_idx, gnt_vld=1, hold_cnt=0, and the state moves to GRANT.
  - Otherwise the block stays in IDLE with outputs zero.
- GRANT, with w = gnt_idx:
  - Release: req[w]=0 → IDLE; gnt, gnt_idx and gnt_vld clear; ptr=w+1 mod 8.
  - Timeout: MAX_HOLD≠0, hold_cnt=MAX_HOLD-1 and req[w]=1 → IDLE; outputs clear; ptr=w+1; timeout=1 for one cycle.
  - Disable: en=0 → IDLE; outputs clear; ptr=w+1; no timeout pulse. Disable has priority over release and timeout.
  - Otherwise the grant is held and hold_cnt increments. With MAX_HOLD=0, hold_cnt saturates at 255 and never times out.
- Changes on req bits other than w are ignored while in GRANT.
- Every exit from GRANT passes through IDLE for one cycle, so there is a minimum one-cycle bubble between grants.
- ptr wraps from 7 to 0.
- gnt is always one-hot or zero, and gnt_idx always equals the encoding of gnt.

## Timing
- Reset values: state=IDLE, ptr=0, hold_cnt=0, gnt=8'h00, gnt_idx=3'b000, gnt_vld=0, timeout=0.
- Reset asserted during GRANT clears everything at that edge, with no timeout pulse. After reset, ptr=0 again.
- Latency: req sampled at edge k while in IDLE → gnt, gnt_idx and gnt_vld valid after edge k (1 cycle).
- Grant duration: at most MAX_HOLD cycles of gnt_vld=1. timeout is high during the first IDLE cycle after revocation.
- Release latency: req[w] falling before edge k → gnt cleared after edge k.
- All outputs are registered; there is no combinational path from req or en to any output.

## Structure
- Package arb_pkg:
  - N_REQ=8, IDX_W=3, HCNT_W=8.
  - Enum arb_state_t {ARB_IDLE, ARB_GRANT}.
- Sub-module onehot_enc8: combinational 8-to-3 one-hot encoder that outputs 3'b000 for non-one-hot input. It is used on the rotated winner vector to form gnt_idx.
- The rotating priority search (rotate by ptr, find first set bit, rotate back) is implemented inside rr_arbiter8.

## Test plan
- Reset, then en=1, req=8'h00 for 5 cycles → gnt=0, gnt_vld=0, gnt_idx=0 throughout.
- Reset, en=1, req=8'b1000_0001 held. Expected:
  - gnt=8'h01, gnt_idx=0 for 16 cycles.
  - timeout pulse, one-cycle bubble.
  - gnt=8'h80, gnt_idx=7 for 16 cycles.
  - timeout, bubble, then gnt=8'h01 (ptr wrap).
- req=8'hFF, with each granted requester dropping its bit 3 cycles after its grant → grant order 0,1,…,7,0, each grant 3 cycles, one bubble between, no timeout.
- Granted requester 5, then en=0 for 1 cycle → gnt=0 next cycle, timeout=0. Then en=1 with req=8'h20|8'h40 → next grant is 6.
- MAX_HOLD=0, req=8'h04 held 300 cycles → gnt=8'h04 continuously, timeout never asserts.
- rst pulsed mid-grant at idx 3 → all outputs 0 after that edge. Next grant with req=8'h18 is idx 3 (ptr=0).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and types for the eight-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HCNT_W = 8;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Priority pointer value that follows a given winner (wraps 7 -> 0).
    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] w);
        return w + IDX_W'(1);
    endfunction

endpackage

// File: rtl/onehot_enc8.sv
// Combinational 8-to-3 one-hot encoder; any non-one-hot input encodes to zero.
module onehot_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    // bit_mask[b] selects every input position whose index has bit b set.
    logic [N_REQ-1:0] bit_mask [IDX_W];
    logic [IDX_W-1:0] idx_raw;
    logic             is_onehot;

    for (genvar gi = 0; gi < IDX_W; gi++) begin : g_idx_bit
        for (genvar gj = 0; gj < N_REQ; gj++) begin : g_pos
            assign bit_mask[gi][gj] = (((gj >> gi) % 2) == 1);
        end
        assign idx_raw[gi] = |(onehot & bit_mask[gi]);
    end

    assign is_onehot = (onehot != '0) &&
                       ((onehot & (onehot - {{(N_REQ-1){1'b0}}, 1'b1})) == '0);

    assign idx = is_onehot ? idx_raw : '0;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant, binary
// grant index, and a hold limit that revokes a grant after MAX_HOLD cycles.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    // MAX_HOLD of zero disables the hold limit entirely.
    localparam bit                HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [HCNT_W-1:0] HOLD_LAST    =
        HCNT_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));

    arb_state_t        state_reg,   state_next;
    logic [IDX_W-1:0]  ptr_reg,     ptr_next;
    logic [HCNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [N_REQ-1:0]  gnt_reg,     gnt_next;
    logic [IDX_W-1:0]  gnt_idx_reg, gnt_idx_next;
    logic              gnt_vld_reg, gnt_vld_next;
    logic              timeout_reg, timeout_next;

    // Rotating priority search: rot_req[0] is the requester at ptr, so the
    // lowest set bit of rot_req is the round-robin winner.
    logic [N_REQ-1:0] rot_req;
    logic [N_REQ-1:0] rot_win;
    logic [N_REQ-1:0] win_vec;
    logic [IDX_W-1:0] rot_idx;
    logic [IDX_W-1:0] win_idx;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot_in
        assign rot_req[gi] = req[IDX_W'(gi) + ptr_reg];
    end

    assign rot_win = rot_req & (~rot_req + {{(N_REQ-1){1'b0}}, 1'b1});

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot_out
        assign win_vec[gi] = rot_win[IDX_W'(gi) - ptr_reg];
    end

    onehot_enc8 u_enc (
        .onehot (rot_win),
        .idx    (rot_idx)
    );

    // The encoder sees the rotated vector, so shift its index back by ptr.
    assign win_idx = rot_idx + ptr_reg;

    // Grant-side conditions evaluated against the current winner.
    logic hold_req;
    logic hold_expired;

    assign hold_req     = req[gnt_idx_reg];
    assign hold_expired = HOLD_LIMITED && (hold_cnt_reg == HOLD_LAST);

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ARB_IDLE;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            gnt_reg      <= '0;
            gnt_idx_reg  <= '0;
            gnt_vld_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            hold_cnt_reg <= hold_cnt_next;
            gnt_reg      <= gnt_next;
            gnt_idx_reg  <= gnt_idx_next;
            gnt_vld_reg  <= gnt_vld_next;
            timeout_reg  <= timeout_next;
        end
    end

    // Next-state logic: issue, hold, release, disable and hold-limit revoke.
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        gnt_next      = gnt_reg;
        gnt_idx_next  = gnt_idx_reg;
        gnt_vld_next  = gnt_vld_reg;
        timeout_next  = 1'b0;

        unique case (state_reg)
            ARB_IDLE: begin
                gnt_next      = '0;
                gnt_idx_next  = '0;
                gnt_vld_next  = 1'b0;
                hold_cnt_next = '0;
                if (en && (req != '0)) begin
                    state_next   = ARB_GRANT;
                    gnt_next     = win_vec;
                    gnt_idx_next = win_idx;
                    gnt_vld_next = 1'b1;
                end
            end

            ARB_GRANT: begin
                if (!en || !hold_req || hold_expired) begin
                    // Disable outranks release and timeout: no pulse when en is low.
                    state_next    = ARB_IDLE;
                    ptr_next      = ptr_after(gnt_idx_reg);
                    hold_cnt_next = '0;
                    gnt_next      = '0;
                    gnt_idx_next  = '0;
                    gnt_vld_next  = 1'b0;
                    timeout_next  = en && hold_req && hold_expired;
                end else if (hold_cnt_reg != '1) begin
                    hold_cnt_next = hold_cnt_reg + HCNT_W'(1);
                end
            end

            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    assign gnt     = gnt_reg;
    assign gnt_idx = gnt_idx_reg;
    assign gnt_vld = gnt_vld_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: one instance with the default hold limit and one
// unlimited instance share the same stimulus and are checked every cycle
// against a behavioural model, plus directed scenario expectations.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;

    logic [7:0] gnt_a, gnt_b;
    logic [2:0] idx_a, idx_b;
    logic       vld_a, vld_b;
    logic       to_a,  to_b;

    logic [12:0] obs_a, obs_b;
    assign obs_a = {gnt_a, idx_a, vld_a, to_a};
    assign obs_b = {gnt_b, idx_b, vld_b, to_b};

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(16)) dut_a (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a), .timeout(to_a)
    );

    rr_arbiter8 #(.MAX_HOLD(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b), .timeout(to_b)
    );

    // Behavioural model: who holds the resource (-1 = nobody), where the
    // round-robin search starts, how long the holder has had it, and
    // whether a hold-limit revocation just happened.
    int m_cur  [2];
    int m_ptr  [2];
    int m_hold [2];
    bit m_to   [2];
    int m_lim  [2];

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cur[i] = -1; m_ptr[i] = 0; m_hold[i] = 0; m_to[i] = 0;
            end else if (m_cur[i] < 0) begin
                m_to[i] = 0;
                if (en && req != 8'h00) begin
                    for (int k = 0; k < 8; k++) begin
                        if (m_cur[i] < 0 && req[(m_ptr[i] + k) % 8]) begin
                            m_cur[i]  = (m_ptr[i] + k) % 8;
                            m_hold[i] = 1;
                        end
                    end
                end
            end else begin
                m_to[i] = 0;
                if (!en || !req[m_cur[i]] || (m_lim[i] != 0 && m_hold[i] >= m_lim[i])) begin
                    m_to[i]  = en && req[m_cur[i]];
                    m_ptr[i] = (m_cur[i] + 1) % 8;
                    m_cur[i] = -1;
                end else begin
                    m_hold[i]++;
                end
            end
        end
    endtask

    function automatic logic [12:0] model_out(input int i);
        logic [7:0] g;
        logic [2:0] x;
        g = (m_cur[i] < 0) ? 8'h00 : (8'h01 << m_cur[i]);
        x = (m_cur[i] < 0) ? 3'd0 : 3'(m_cur[i]);
        return {g, x, (m_cur[i] >= 0), m_to[i]};
    endfunction

    // Advance one clock; inputs are already stable, outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; req = 8'h00;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 2;
        if (obs_a !== 13'h0) begin fails++; $display("FAIL reset_a: got %h want 0", obs_a); end
        if (obs_b !== 13'h0) begin fails++; $display("FAIL reset_b: got %h want 0", obs_b); end
        en = 1'b1; req = 8'h00;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({obs_a, obs_b} !== 26'h0)
                begin fails++; $display("FAIL idle_noreq cyc %0d: got %h/%h want 0/0", c, obs_a, obs_b); end
        end
    endtask

    task automatic test_hold_limit();
        logic [12:0] exp_a, exp_b, want;
        do_reset();
        en = 1'b1; req = 8'b1000_0001;
        for (int c = 1; c <= 35; c++) begin
            step();
            exp_a = model_out(0); exp_b = model_out(1);
            checks += 3;
            if (obs_a !== exp_a) begin fails++; $display("FAIL hold_model_a cyc %0d: got %h want %h", c, obs_a, exp_a); end
            if (obs_b !== exp_b) begin fails++; $display("FAIL hold_model_b cyc %0d: got %h want %h", c, obs_b, exp_b); end
            if (c <= 16)       want = {8'h01, 3'd0, 1'b1, 1'b0};
            else if (c == 17)  want = {8'h00, 3'd0, 1'b0, 1'b1};
            else if (c <= 33)  want = {8'h80, 3'd7, 1'b1, 1'b0};
            else if (c == 34)  want = {8'h00, 3'd0, 1'b0, 1'b1};
            else               want = {8'h01, 3'd0, 1'b1, 1'b0};
            if (obs_a !== want) begin fails++; $display("FAIL hold_seq cyc %0d: got %h want %h", c, obs_a, want); end
        end
    endtask

    task automatic test_rotation();
        logic [12:0] exp_a, exp_b;
        int order [9];
        int n, held;
        bit prev;
        do_reset();
        en = 1'b1; req = 8'hFF; n = 0; held = 0; prev = 1'b0;
        for (int c = 0; c < 80 && n < 9; c++) begin
            step();
            exp_a = model_out(0); exp_b = model_out(1);
            checks += 2;
            if (obs_a !== exp_a) begin fails++; $display("FAIL rot_model_a cyc %0d: got %h want %h", c, obs_a, exp_a); end
            if (obs_b !== exp_b) begin fails++; $display("FAIL rot_model_b cyc %0d: got %h want %h", c, obs_b, exp_b); end
            if (vld_a && !prev) begin order[n] = int'(idx_a); n++; end
            prev = vld_a;
            if (m_cur[0] >= 0) begin
                held++;
                if (held == 3) req = 8'hFF & ~(8'h01 << m_cur[0]);
            end else begin
                held = 0;
                req  = 8'hFF;
            end
        end
        checks++;
        if (n !== 9) begin fails++; $display("FAIL rot_count: got %0d grants want 9", n); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (order[k] !== k % 8) begin fails++; $display("FAIL rot_order %0d: got %0d want %0d", k, order[k], k % 8); end
        end
    endtask

    task automatic test_disable();
        do_reset();
        en = 1'b1; req = 8'h20;
        step();
        checks++;
        if (obs_a !== {8'h20, 3'd5, 1'b1, 1'b0}) begin fails++; $display("FAIL dis_grant5: got %h want %h", obs_a, {8'h20, 3'd5, 1'b1, 1'b0}); end
        en = 1'b0;
        step();
        checks++;
        if (obs_a !== 13'h0) begin fails++; $display("FAIL dis_revoke: got %h want 0", obs_a); end
        en = 1'b1; req = 8'h60;
        step();
        checks += 2;
        if (obs_a !== {8'h40, 3'd6, 1'b1, 1'b0}) begin fails++; $display("FAIL dis_next6: got %h want %h", obs_a, {8'h40, 3'd6, 1'b1, 1'b0}); end
        if (obs_b !== model_out(1)) begin fails++; $display("FAIL dis_model_b: got %h want %h", obs_b, model_out(1)); end
    endtask

    task automatic test_unlimited();
        logic [12:0] exp_a;
        do_reset();
        en = 1'b1; req = 8'h04;
        for (int c = 0; c < 300; c++) begin
            step();
            exp_a = model_out(0);
            checks += 2;
            if (obs_b !== {8'h04, 3'd2, 1'b1, 1'b0}) begin fails++; $display("FAIL unlim_b cyc %0d: got %h want %h", c, obs_b, {8'h04, 3'd2, 1'b1, 1'b0}); end
            if (obs_a !== exp_a) begin fails++; $display("FAIL unlim_model_a cyc %0d: got %h want %h", c, obs_a, exp_a); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1; req = 8'h08;
        step(); step(); step();
        checks++;
        if (obs_a !== {8'h08, 3'd3, 1'b1, 1'b0}) begin fails++; $display("FAIL rmid_grant3: got %h want %h", obs_a, {8'h08, 3'd3, 1'b1, 1'b0}); end
        rst = 1'b1;
        step();
        checks++;
        if ({obs_a, obs_b} !== 26'h0) begin fails++; $display("FAIL rmid_clear: got %h/%h want 0/0", obs_a, obs_b); end
        rst = 1'b0; req = 8'h18;
        step();
        checks++;
        if (obs_a !== {8'h08, 3'd3, 1'b1, 1'b0}) begin fails++; $display("FAIL rmid_after: got %h want %h", obs_a, {8'h08, 3'd3, 1'b1, 1'b0}); end
    endtask

    task automatic test_random();
        logic [12:0] exp_a, exp_b;
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0)   req = 8'($urandom_range(0, 255));
            en  = ($urandom_range(0, 31) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
            exp_a = model_out(0); exp_b = model_out(1);
            checks += 2;
            if (obs_a !== exp_a) begin fails++; $display("FAIL rand_a cyc %0d: got %h want %h", c, obs_a, exp_a); end
            if (obs_b !== exp_b) begin fails++; $display("FAIL rand_b cyc %0d: got %h want %h", c, obs_b, exp_b); end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_lim[0] = 16;
        m_lim[1] = 0;
        for (int i = 0; i < 2; i++) begin
            m_cur[i] = -1; m_ptr[i] = 0; m_hold[i] = 0; m_to[i] = 0;
        end
        test_reset();
        test_hold_limit();
        test_rotation();
        test_disable();
        test_unlimited();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
